// File: rtl/shift_register_readback_pkg.sv
// Shared constants and the FSM state encoding for the configuration-bus
// readback serialiser.
package shift_register_readback_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACQUIRE = 3'd1,
    READ    = 3'd2,
    WAIT    = 3'd3,
    SHIFT   = 3'd4,
    DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/shift_register_readback_if.sv
// Configuration-bus daisy-chain segment seen by the readback block.
//
// Handshake: Conf_Free_In high means no upstream agent owns the bus. The
// block may take the bus only on an edge where Conf_Free_In is sampled high;
// while it owns the bus it drives Conf_Free_Out low, issues a one-cycle
// Conf_Read_Out strobe, and the memory returns Conf_Data_In a fixed number of
// cycles later (no ready/back-pressure on this bus). When not owning the bus,
// all *_Out signals pass the matching *_In signals through combinationally.
interface shift_register_readback_if;
  import shift_register_readback_pkg::*;

  logic              Conf_Free_In;
  logic              Conf_Free_Out;
  logic              Conf_Read_In;
  logic              Conf_Read_Out;
  logic [DATA_W-1:0] Conf_Address_In;
  logic [DATA_W-1:0] Conf_Address_Out;
  logic [DATA_W-1:0] Conf_Data_In;

  // Readback block side
  modport master (
    input  Conf_Free_In, Conf_Read_In, Conf_Address_In, Conf_Data_In,
    output Conf_Free_Out, Conf_Read_Out, Conf_Address_Out
  );

  // Chain / memory side
  modport slave (
    output Conf_Free_In, Conf_Read_In, Conf_Address_In, Conf_Data_In,
    input  Conf_Free_Out, Conf_Read_Out, Conf_Address_Out
  );

endinterface

// File: rtl/shift_register_readback_tmr_vote.sv
// Bitwise 2-of-3 majority voter for a triplicated register group.
module tmr_vote #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] y
);

  assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/shift_register_readback.sv
// Reads Num_Words configuration words starting at Base_Address and shifts each
// one out MSB-first on SR_Out. The bus is held only for the read of one word
// and released while that word is being shifted. Every state register is kept
// in three copies; logic and outputs only ever see the voted value.
module shift_register_readback
  import shift_register_readback_pkg::*;
#(
  parameter int READ_LAT = 2,
  parameter int CNT_W    = 12
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [DATA_W-1:0] Base_Address,
  input  logic [CNT_W-1:0]  Num_Words,
  input  logic              Shift_En,
  shift_register_readback_if.master bus,
  output logic              SR_Out,
  output logic              SR_Valid,
  output logic              Busy,
  output logic              Done,
  output state_t            state
);

  // Datapath registers that share one voter.
  typedef struct packed {
    logic              own;
    logic [2:0]        lat;
    logic [3:0]        bitc;
    logic [CNT_W-1:0]  widx;
    logic [CNT_W-1:0]  nw;
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] sr;
  } dp_t;

  localparam int DP_W = $bits(dp_t);

  logic [2:0]      state_q0, state_q1, state_q2;
  logic [2:0]      state_v;
  dp_t             dp_q0, dp_q1, dp_q2;
  logic [DP_W-1:0] dp_v;
  state_t          st, n_state;
  dp_t             cur, n_dp;
  logic            rd_strobe;
  logic [CNT_W:0]  widx_inc;

  tmr_vote #(.WIDTH(3)) u_state_vote (
    .a(state_q0), .b(state_q1), .c(state_q2), .y(state_v)
  );

  tmr_vote #(.WIDTH(DP_W)) u_dp_vote (
    .a(dp_q0), .b(dp_q1), .c(dp_q2), .y(dp_v)
  );

  assign st       = state_t'(state_v);
  assign cur      = dp_t'(dp_v);
  assign widx_inc = {1'b0, cur.widx} + {{CNT_W{1'b0}}, 1'b1};

  // All three copies reload from the voted next value, scrubbing a bad copy.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q0 <= IDLE;
      state_q1 <= IDLE;
      state_q2 <= IDLE;
      dp_q0    <= '0;
      dp_q1    <= '0;
      dp_q2    <= '0;
    end else begin
      state_q0 <= n_state;
      state_q1 <= n_state;
      state_q2 <= n_state;
      dp_q0    <= n_dp;
      dp_q1    <= n_dp;
      dp_q2    <= n_dp;
    end
  end

  // Next-state and datapath update for the acquire/read/wait/shift sequence.
  always_comb begin
    n_state   = st;
    n_dp      = cur;
    rd_strobe = 1'b0;
    case (st)
      IDLE: begin
        if (Start) begin
          n_dp.base = Base_Address;
          n_dp.nw   = Num_Words;
          n_dp.widx = '0;
          n_dp.bitc = '0;
          n_state   = (Num_Words == '0) ? DONE : ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (bus.Conf_Free_In) begin
          n_dp.own = 1'b1;
          n_state  = READ;
        end
      end
      READ: begin
        rd_strobe = 1'b1;
        n_dp.lat  = 3'(READ_LAT - 1);
        n_state   = WAIT;
      end
      WAIT: begin
        if (cur.lat == 3'd0) begin
          n_dp.sr   = bus.Conf_Data_In;
          n_dp.own  = 1'b0;
          n_dp.bitc = '0;
          n_state   = SHIFT;
        end else begin
          n_dp.lat = cur.lat - 3'd1;
        end
      end
      SHIFT: begin
        if (Shift_En) begin
          n_dp.sr   = {cur.sr[DATA_W-2:0], 1'b0};
          n_dp.bitc = cur.bitc + 4'd1;
          if (cur.bitc == 4'd15) begin
            n_dp.widx = widx_inc[CNT_W-1:0];
            n_state   = (widx_inc < {1'b0, cur.nw}) ? ACQUIRE : DONE;
          end
        end
      end
      DONE:    n_state = IDLE;
      default: n_state = IDLE;
    endcase
  end

  assign state    = st;
  assign SR_Out   = cur.sr[DATA_W-1];
  assign SR_Valid = Shift_En & (st == SHIFT);
  assign Busy     = (st == ACQUIRE) || (st == READ) || (st == WAIT) || (st == SHIFT);
  assign Done     = (st == DONE);

  // Bus mux: pass-through unless this block currently owns the bus.
  assign bus.Conf_Free_Out    = cur.own ? 1'b0 : bus.Conf_Free_In;
  assign bus.Conf_Read_Out    = cur.own ? rd_strobe : bus.Conf_Read_In;
  assign bus.Conf_Address_Out = cur.own ? (cur.base + DATA_W'(cur.widx))
                                        : bus.Conf_Address_In;

endmodule

// File: doc/shift_register_readback.md
Name: shift_register_readback

Overview:
- Reads a block of 16-bit words from the configuration bus and serialises them MSB-first onto a serial output.
- It is the readback counterpart of the serial-to-configuration-bus writer in the FEI4 emulator.
- It sits in the same configuration-bus daisy chain and takes bus ownership with the Conf_Free handshake.
- All state registers are triple-redundant with bitwise majority voting.

Parameters:
- READ_LAT, 2, Clk cycles from Conf_Read_Out asserted to Conf_Data_In valid (1..7).
- CNT_W, 12, width of the word counter and of Num_Words.

Ports:
- Clk  input  1  system clock; all logic on posedge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle request to begin a readback.
- Base_Address  input  16  first configuration address to read; sampled on an accepted Start.
- Num_Words  input  CNT_W  number of words to read; sampled on an accepted Start.
- Shift_En  input  1  serial-output clock enable; one bit advances per Clk while high.
- Conf_Free_In  input  1  bus-free indication from upstream.
- Conf_Free_Out  output  1  bus-free indication to downstream.
- Conf_Read_In  input  1  upstream read strobe (pass-through).
- Conf_Read_Out  output  1  read strobe to the configuration memory.
- Conf_Address_In  input  16  upstream address (pass-through).
- Conf_Address_Out  output  16  address to the configuration memory.
- Conf_Data_In  input  16  read data returned by the memory.
- SR_Out  output  1  serial data, MSB first.
- SR_Valid  output  1  high for each Clk in which SR_Out carries a bit being shifted.
- Busy  output  1  high from an accepted Start until Done.
- Done  output  1  one-cycle pulse when the transfer completes.

Behaviour:
- Reset values:
  - State IDLE; Own=0; counters 0; shift register 0.
  - SR_Out=0, SR_Valid=0, Busy=0, Done=0.
  - Conf_Read_Out=Conf_Read_In, Conf_Address_Out=Conf_Address_In, Conf_Free_Out=Conf_Free_In.
- Bus mux:
  - Own=0: Conf_Read_Out, Conf_Address_Out and Conf_Free_Out pass the corresponding inputs through combinationally.
  - Own=1: Conf_Free_Out=0, Conf_Address_Out=Base_Address+WordIdx (mod 2^16), Conf_Read_Out=internal read strobe.
- IDLE:
  - Start accepted -> sample Base_Address and Num_Words, set Busy=1, go to ACQUIRE.
  - Start with Num_Words=0 -> Done pulse on the next cycle; Busy stays 0; the bus is never taken.
- ACQUIRE:
  - Wait for Conf_Free_In=1, then set Own=1 on the same edge and go to READ.
- READ:
  - Conf_Read_Out=1 for exactly one cycle at the current address, then go to WAIT.
  - A latency counter loads READ_LAT-1.
- WAIT:
  - Decrement the latency counter; at 0, capture Conf_Data_In into the 16-bit shift register.
  - Set Own=0 on the same edge, releasing the bus during shifting, then go to SHIFT.
- SHIFT:
  - SR_Out = shift register bit 15.
  - SR_Valid = Shift_En & (state==SHIFT).
  - Each Clk with Shift_En=1: shift left by one and increment the bit counter.
  - After the 16th shifted bit: WordIdx+1.
    - If WordIdx+1 < Num_Words -> ACQUIRE.
    - Else -> DONE.
  - Shift_En low stalls the shift with no bit loss.
- DONE:
  - Done=1 for one cycle, Busy=0, return to IDLE.
- Start while Busy=1 is ignored.
- Conf_Free_In dropping in ACQUIRE before it is sampled high: keep waiting.
- Once Own=1, the block ignores Conf_Free_In until the word is captured.
- Asynchronous Reset mid-transfer: immediately Own=0 (pass-through restored), outputs at reset values, no Done pulse.
- Address wrap: Base_Address=16'hFFFF with 2 words reads FFFF then 0000.
- Num_Words = 2^CNT_W-1 is the maximum transfer.
- Redundancy:
  - State, Own, counters and shift register are each held in three copies, written from the voted value.
  - The voted value drives both logic and outputs.
  - A single corrupted copy must not change any output.

Decomposition:
- Shared package: state encoding constants (IDLE, ACQUIRE, READ, WAIT, SHIFT, DONE) and the data/address width constant (16).
- Sub-module tmr_vote (parameter WIDTH): bitwise 2-of-3 majority voter, instantiated once per triplicated register group.

Test Plan:
- Base_Address=16'h0010, Num_Words=1, Conf_Free_In=1, memory[0x10]=16'hA5C3, Shift_En=1 -> Conf_Read_Out one pulse with address 0x0010; SR_Out bits 1010010111000011 with SR_Valid high for 16 cycles; then Done pulse and Busy=0.
- Num_Words=3 from 0x0100, READ_LAT=2 -> three read strobes at 0x0100, 0x0101, 0x0102; 48 valid bits in order; bus is released (Conf_Free_Out follows Conf_Free_In) during every SHIFT.
- Conf_Free_In=0 for 20 cycles after Start -> no Conf_Read_Out, Own stays 0, pass-through intact; read occurs one cycle after Conf_Free_In rises.
- Shift_En toggled 1010... during SHIFT -> exactly 16 valid bits, correct data, word completion takes 32 cycles.
- Reset asserted during WAIT of word 2 -> Conf_Address_Out equals Conf_Address_In immediately; SR_Valid=0, Busy=0, Done never pulses.
- Num_Words=0 -> no bus activity, Done one cycle after Start. Separately: force one copy of a state register to a wrong value -> transfer identical to the fault-free run.
